// File: rtl/game_soc_keycode_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : game_soc_keycode_fifo
//  Brief    : Avalon-MM keycode FIFO with a streaming consumer port, sticky
//             overflow flag, last-popped register and level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module game_soc_keycode_fifo #(
    parameter  int DATA_W = 24,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_irq_en = 2'd2;
    localparam logic [1:0] c_addr_last   = 2'd3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic [1:0]        r_irq_en;
    logic [DATA_W-1:0] r_last;
    logic              r_irq;

    logic              w_wr;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_flush;
    logic              w_ovf_clr;
    logic              w_empty;
    logic              w_full;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_ovf_nxt;
    logic [1:0]        w_irq_en_nxt;
    logic [31:0]       w_readdata;
    logic              w_unused;

    // Bus decode and FIFO handshake qualifiers
    assign w_wr      = chipselect & ~write_n;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = ~w_empty & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_push    = w_wr & (address == c_addr_data) & (~w_full | w_pop);
    assign w_drop    = w_wr & (address == c_addr_data) & w_full & ~w_pop;
    assign w_flush   = w_wr & (address == c_addr_status) & writedata[31];
    assign w_ovf_clr = w_wr & (address == c_addr_status) & writedata[2];
    assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_unused  = &{1'b0, writedata};

    // Next-state values shared by the state registers and the irq register
    always_comb begin
        w_count_nxt  = r_count;
        w_ovf_nxt    = r_ovf;
        w_irq_en_nxt = r_irq_en;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
        // Overflow set takes priority over a clear on the same edge
        if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end else if (w_ovf_clr) begin
            w_ovf_nxt = 1'b0;
        end
        if (w_wr && (address == c_addr_irq_en)) begin
            w_irq_en_nxt = writedata[1:0];
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    // Control state: pointers, occupancy, flags, last-popped and interrupt
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq_en <= 2'b00;
            r_last   <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
            // LAST captures the popped head even when a flush wins the pointers
            if (w_pop) begin
                r_last <= w_head;
            end
            r_count  <= w_count_nxt;
            r_ovf    <= w_ovf_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= (w_irq_en_nxt[0] & (w_count_nxt == '0)) |
                        (w_irq_en_nxt[1] & w_ovf_nxt);
        end
    end

    // Zero-latency register read mux
    always_comb begin
        w_readdata = '0;
        case (address)
            c_addr_data: begin
                w_readdata[DATA_W-1:0] = w_head;
            end
            c_addr_status: begin
                w_readdata[0]            = w_empty;
                w_readdata[1]            = w_full;
                w_readdata[2]            = r_ovf;
                w_readdata[CNT_W+15:16]  = r_count;
            end
            c_addr_irq_en: begin
                w_readdata[1:0] = r_irq_en;
            end
            c_addr_last: begin
                w_readdata[DATA_W-1:0] = r_last;
            end
            default: begin
                w_readdata = '0;
            end
        endcase
    end

    assign readdata  = w_readdata;
    assign out_data  = w_head;
    assign out_valid = ~w_empty;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_game_soc_keycode_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_soc_keycode_fifo
//  Brief    : Directed and randomized bench for game_soc_keycode_fifo against
//             a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_soc_keycode_fifo;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam logic [31:0] c_mask = (DATA_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << DATA_W) - 32'd1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              irq;

    always #5 clk = ~clk;

    game_soc_keycode_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    // Reference model state
    logic [31:0] mq[$];
    bit          m_ovf;
    bit [1:0]    m_en;
    logic [31:0] m_last;
    bit          m_irq;
    bit          model_ok = 1'b0;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] sampled_rd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = (mq.size() != 0) ? mq[0] : 32'd0;
            2'd1: begin
                r[0]     = (mq.size() == 0);
                r[1]     = (mq.size() == DEPTH);
                r[2]     = m_ovf;
                r[31:16] = 16'(mq.size());
            end
            2'd2: r[1:0] = m_en;
            default: r = m_last;
        endcase
        return r;
    endfunction

    // Model of one clock edge, written from the register-level rules
    task automatic model_edge(input bit rn, input bit cs, input bit wn,
                              input logic [1:0] a, input logic [31:0] wd, input bit rdy);
        bit wr, pop;
        int size0;
        if (!rn) begin
            mq.delete();
            m_ovf = 0; m_en = 0; m_last = 0; m_irq = 0;
            return;
        end
        wr    = cs && !wn;
        size0 = mq.size();
        pop   = (size0 != 0) && rdy;
        if (pop) m_last = mq.pop_front();
        if (wr && a == 2'd1) begin
            if (wd[2])  m_ovf = 0;
            if (wd[31]) mq.delete();
        end
        if (wr && a == 2'd0) begin
            if (size0 < DEPTH || pop) mq.push_back(wd & c_mask);
            else m_ovf = 1;
        end
        if (wr && a == 2'd2) m_en = wd[1:0];
        m_irq = (m_en[0] && mq.size() == 0) || (m_en[1] && m_ovf);
    endtask

    // Drive one cycle, compare pre-edge outputs against the model, then clock it
    task automatic step(input bit rn, input bit cs, input bit wn,
                        input logic [1:0] a, input logic [31:0] wd, input bit rdy);
        @(negedge clk);
        reset_n = rn; chipselect = cs; write_n = wn;
        address = a; writedata = wd; out_ready = rdy;
        #1;
        sampled_rd = readdata;
        if (model_ok) begin
            check_eq("readdata", readdata, model_rd(a));
            check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check_eq("irq", 32'(irq), 32'(m_irq));
            if (mq.size() != 0) check_eq("out_data", 32'(out_data), mq[0]);
        end
        @(posedge clk);
        model_edge(rn, cs, wn, a, wd, rdy);
        model_ok = 1'b1;
    endtask

    task automatic idle(input logic [1:0] a);
        step(1, 0, 1, a, 32'd0, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1, 1, 0, a, d, 0);
    endtask

    initial begin
        int rdy_pct;
        int r;
        bit rn, cs, wn, rdy;
        logic [1:0] a;
        logic [31:0] wd;

        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; out_ready = 0;
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 32'h1234, 1);

        // Reset state
        idle(1);
        check_eq("reset_status", sampled_rd, 32'h0000_0001);

        // Single push latency
        wr(0, 32'h0000_001C);
        idle(1);
        check_eq("push_status", sampled_rd, 32'h0001_0000);
        idle(0);
        check_eq("push_data", sampled_rd, 32'h0000_001C);
        check_eq("push_out_data", 32'(out_data), 32'h0000_001C);

        // Fill, overflow, clear
        wr(1, 32'h8000_0000);
        for (int i = 1; i <= 8; i++) wr(0, 32'(i));
        idle(1);
        check_eq("full_status", sampled_rd, 32'h0008_0002);
        wr(0, 32'h99);
        idle(1);
        check_eq("ovf_status", sampled_rd, 32'h0008_0006);
        wr(1, 32'h4);
        idle(1);
        check_eq("ovf_clear", sampled_rd, 32'h0008_0002);

        // Push into a full FIFO while popping
        step(1, 1, 0, 0, 32'h55, 1);
        idle(1);
        check_eq("fullpop_status", sampled_rd, 32'h0008_0002);
        idle(3);
        check_eq("fullpop_last", sampled_rd, 32'h0000_0001);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 1);
        idle(3);
        check_eq("tail_last", sampled_rd, 32'h0000_0055);

        // Empty interrupt
        wr(2, 32'h1);
        idle(1);
        check_eq("irq_empty", 32'(irq), 32'd1);
        wr(0, 32'h77);
        idle(1);
        check_eq("irq_clr", 32'(irq), 32'd0);
        step(1, 0, 1, 1, 0, 1);
        idle(1);
        check_eq("irq_after_pop", 32'(irq), 32'd1);

        // Flush keeps OVF
        for (int i = 0; i < 9; i++) wr(0, 32'(i + 16));
        wr(1, 32'h8000_0000);
        idle(1);
        check_eq("flush_status", sampled_rd, 32'h0000_0005);
        idle(0);
        check_eq("flush_data", sampled_rd, 32'd0);
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        wr(1, 32'h4);

        // Reset during a pop
        wr(0, 32'h2A);
        step(0, 1, 0, 2, 32'h3, 1);
        idle(3);
        check_eq("rst_last", sampled_rd, 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);

        // Randomized traffic in phases of varying consumer readiness
        for (int ph = 0; ph < 15; ph++) begin
            rdy_pct = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                rn  = ($urandom_range(0, 199) != 0);
                cs  = ($urandom_range(0, 3) != 0);
                wn  = ($urandom_range(0, 2) == 0);
                r   = $urandom_range(0, 9);
                a   = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
                wd  = $urandom;
                if (a == 2'd1 && $urandom_range(0, 7) != 0) wd[31] = 1'b0;
                rdy = ($urandom_range(0, 99) < rdy_pct);
                step(rn, cs, wn, a, wd, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_soc_keycode_fifo.md
GAME_SOC_KEYCODE_FIFO -- requirements
Module: game_soc_keycode_fifo

Parameters
REQ-001 DATA_W, default 24, keycode width; SHALL be 1..32.
REQ-002 DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..256.
REQ-003 CNT_W, default $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Interface
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  2  Avalon-MM register select.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, zero wait states, read latency 0 (combinational from address and state).
REQ-011 out_data  output  DATA_W  FIFO head entry to hardware consumer.
REQ-012 out_valid  output  1  FIFO not empty.
REQ-013 out_ready  input  1  consumer accepts head.
REQ-014 irq  output  1  level interrupt, registered.

Function
REQ-015 Write strobe: wr = chipselect & ~write_n; register writes take effect at the clock edge of the strobe cycle.
REQ-016 Addr 0 DATA write: not full -> push writedata[DATA_W-1:0]; full and no pop that cycle -> drop data, set sticky OVF.
REQ-017 Addr 0 DATA read: head entry zero-extended to 32; 0 when empty; no pop on read.
REQ-018 Addr 1 STATUS read: bit0 EMPTY, bit1 FULL, bit2 OVF, bits[CNT_W+15:16] count; other bits 0.
REQ-019 Addr 1 STATUS write: writedata[2]=1 clears OVF; writedata[31]=1 flushes FIFO (count, pointers to 0); other bits ignored.
REQ-020 Addr 2 IRQ_EN: bit0 EMPTY_EN, bit1 OVF_EN; read/write; bits[31:2] read 0.
REQ-021 Addr 3 LAST read: most recently popped entry, zero-extended; writes ignored.
REQ-022 Pop: out_valid & out_ready at an edge removes head and loads LAST with it.
REQ-023 out_valid = (count != 0); out_data = head entry, value undefined-but-stable when empty (0 in RTL).
REQ-024 Push latency: push at edge N -> out_valid high and count updated after edge N.
REQ-025 Simultaneous push and pop: both occur, count unchanged; when full, the push is accepted (no OVF).
REQ-026 Push while empty: out_valid low that cycle, so no pop; entry appears next cycle.
REQ-027 Flush with pop same edge: flush wins for count/pointers; LAST still loads popped head.
REQ-028 Flush with OVF-clear same write: both take effect.
REQ-029 OVF set and OVF-clear same edge: set wins.
REQ-030 Pointers wrap modulo DEPTH; count in 0..DEPTH; FULL = (count == DEPTH).
REQ-031 irq register loads ((EMPTY_EN & empty) | (OVF_EN & OVF)) from next-state values; asserts one edge after the condition arises.

Reset
REQ-032 reset_n low at an edge: count, pointers, OVF, IRQ_EN, LAST, irq all 0; out_valid 0; FIFO storage need not reset.
REQ-033 Reset dominates any simultaneous bus write or pop.
REQ-034 Reset mid-operation discards all queued entries; no pop handshake completes on that edge.

Verification
REQ-035 Reset, then push 0x00001C (DEPTH=8) -> next cycle out_valid=1, out_data=0x00001C, STATUS=0x0001_0000.
REQ-036 Push 8 entries 1..8, out_ready=0 -> STATUS FULL=1, count=8; 9th push 0x99 -> dropped, OVF=1; write STATUS 0x4 -> OVF=0.
REQ-037 Full FIFO, push 0x55 with out_ready=1 same cycle -> count stays 8, OVF=0, LAST=1, tail=0x55.
REQ-038 IRQ_EN=1, FIFO empty -> irq=1; push one entry -> irq=0 next cycle; pop it -> irq=1 one cycle after pop.
REQ-039 Entries queued, write STATUS 0x8000_0000 -> count=0, out_valid=0, DATA read=0; OVF preserved.
REQ-040 Push 0x2A, drive reset_n=0 while out_ready=1 -> out_valid=0, LAST=0, irq=0 after edge.
